// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage MIPS32 pipeline: arbitrates MDU waits, hazard stalls
// and ID-stage branch flushes, and keeps saturating stall/flush counters plus a hazard watchdog.
module pipeline_stall_controller #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_stall,
    input  logic             ctrl_noop_req,
    input  logic             branch_taken_ID,
    input  logic             mdu_start,
    input  logic             mdu_done,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_timeout
);

    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_HAZ = 2'b01,
        ST_MDU = 2'b10
    } state_t;

    localparam logic [7:0] MAX_STALL_W = 8'(MAX_STALL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [7:0]       wd_q, wd_d;
    logic             timeout_q, timeout_d;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [7:0] sat_inc_wd(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d       = state_q;
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;

        if (state_q == ST_MDU) begin
            if (mdu_done) begin
                state_d = ST_RUN;
            end else begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_bubble = 1'b1;
            end
        end else if (mdu_start) begin
            // The MDU instruction itself advances into EX normally; the wait starts next cycle.
            state_d = mdu_done ? ST_RUN : ST_MDU;
        end else if (hazard_stall) begin
            // Any branch seen now is re-evaluated once the stalled instruction moves on.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            state_d      = ST_HAZ;
        end else begin
            id_ex_bubble = ctrl_noop_req;
            if_id_flush  = branch_taken_ID;
            state_d      = ST_RUN;
        end

        if (reset) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = ST_RUN;
        end
    end

    always_comb begin
        stall_d = pc_en       ? stall_q : sat_inc_cnt(stall_q);
        flush_d = if_id_flush ? sat_inc_cnt(flush_q) : flush_q;
        // Hazard requests seen while waiting on the MDU neither advance nor clear the watchdog.
        if (!hazard_stall)          wd_d = 8'd0;
        else if (state_q != ST_MDU) wd_d = sat_inc_wd(wd_q);
        else                        wd_d = wd_q;
        timeout_d = timeout_q | (wd_d >= MAX_STALL_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            stall_q   <= '0;
            flush_q   <= '0;
            wd_q      <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign state         = state_q;
    assign stall_cycles  = stall_q;
    assign flush_count   = flush_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scenario bench for pipeline_stall_controller: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_stall_controller;

    localparam int TCW  = 6;
    localparam int TMAX = 4;
    localparam logic [TCW-1:0] MAXC = '1;

    logic clk = 1'b0;
    logic reset = 1'b1, hazard_stall = 1'b0, ctrl_noop_req = 1'b0, branch_taken_ID = 1'b0;
    logic mdu_start = 1'b0, mdu_done = 1'b0;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, stall_timeout;
    logic [1:0] state;
    logic [TCW-1:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    // Model state: mode 0 = running, 1 = stalled on hazard, 2 = waiting on MDU
    int m_mode = 0, m_stall = 0, m_flush = 0, m_wd = 0;
    bit m_to = 0;
    bit e_pc, e_ifid, e_fl, e_idex, e_bub, e_exb;

    pipeline_stall_controller #(.CNT_W(TCW), .MAX_STALL(TMAX)) dut (
        .clk(clk), .reset(reset), .hazard_stall(hazard_stall), .ctrl_noop_req(ctrl_noop_req),
        .branch_taken_ID(branch_taken_ID), .mdu_start(mdu_start), .mdu_done(mdu_done),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
        .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .state(state),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic model_outputs();
        bit waiting;
        {e_pc, e_ifid, e_idex, e_fl, e_bub, e_exb} = 6'b111000;
        if (reset) begin
            {e_pc, e_ifid, e_idex, e_fl, e_bub, e_exb} = 6'b000111;
        end else if (m_mode == 2) begin
            waiting = !mdu_done;
            e_pc = !waiting; e_ifid = !waiting; e_idex = !waiting; e_exb = waiting;
        end else if (mdu_start) begin
            // entry cycle is a normal cycle
        end else if (hazard_stall) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else begin
            e_bub = ctrl_noop_req; e_fl = branch_taken_ID;
        end
    endtask

    task automatic model_next();
        if (reset) begin
            m_mode = 0; m_stall = 0; m_flush = 0; m_wd = 0; m_to = 0;
        end else begin
            if (!e_pc && m_stall < int'(MAXC)) m_stall++;
            if (e_fl && m_flush < int'(MAXC)) m_flush++;
            if (!hazard_stall) m_wd = 0;
            else if (m_mode != 2 && m_wd < 255) m_wd++;
            if (m_wd >= TMAX) m_to = 1;
            if (m_mode == 2)                 m_mode = mdu_done ? 0 : 2;
            else if (mdu_start && !mdu_done) m_mode = 2;
            else if (mdu_start)              m_mode = 0;
            else if (hazard_stall)           m_mode = 1;
            else                             m_mode = 0;
        end
    endtask

    task automatic drive(input logic r, input logic h, input logic n, input logic b,
                         input logic s, input logic d);
        reset = r; hazard_stall = h; ctrl_noop_req = n; branch_taken_ID = b;
        mdu_start = s; mdu_done = d;
        @(negedge clk);
        model_outputs();
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_dut();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0); tick();
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0);
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en: got %0b want 0", pc_en); end
        checks++; if (if_id_flush !== 1'b1) begin errors++; $display("FAIL reset_flush: got %0b want 1", if_id_flush); end
        checks++; if ({id_ex_en, id_ex_bubble, ex_mem_bubble} !== 3'b011) begin errors++; $display("FAIL reset_idex_exmem: got %b want 011", {id_ex_en, id_ex_bubble, ex_mem_bubble}); end
        tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL post_reset_state: got %b want 00", state); end
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL post_reset_pc_en: got %0b want 1", pc_en); end
        checks++; if ({stall_cycles, flush_count} !== '0) begin errors++; $display("FAIL post_reset_counters: got %0d/%0d want 0/0", stall_cycles, flush_count); end
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL post_reset_timeout: got %0b want 0", stall_timeout); end
        tick();
    endtask

    task automatic test_hazard();
        rst_dut();
        drive(0, 1, 0, 0, 0, 0);
        checks++; if ({pc_en, if_id_en, id_ex_en, id_ex_bubble, if_id_flush, state} !== 7'b0011000) begin errors++; $display("FAIL haz1_outputs: got %b want 0011000", {pc_en, if_id_en, id_ex_en, id_ex_bubble, if_id_flush, state}); end
        tick();
        drive(0, 1, 0, 0, 0, 0);
        checks++; if ({pc_en, id_ex_bubble, state} !== 4'b0101) begin errors++; $display("FAIL haz2_outputs: got %b want 0101", {pc_en, id_ex_bubble, state}); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL haz_release_pc_en: got %0b want 1", pc_en); end
        checks++; if (stall_cycles !== TCW'(2)) begin errors++; $display("FAIL haz_stall_cycles: got %0d want 2", stall_cycles); end
        checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL haz_no_timeout: got %0b want 0", stall_timeout); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL haz_back_to_run: got %b want 00", state); end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 0, 0);
            checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL wd_early_timeout cycle %0d: got %0b want 0", i, stall_timeout); end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout_sticky cycle %0d: got %0b want 1", i, stall_timeout); end
            tick();
        end
    endtask

    task automatic test_mdu();
        rst_dut();
        drive(0, 0, 0, 0, 1, 0);
        checks++; if ({pc_en, id_ex_en, ex_mem_bubble, state} !== 5'b11000) begin errors++; $display("FAIL mdu_entry: got %b want 11000", {pc_en, id_ex_en, ex_mem_bubble, state}); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            checks++; if ({pc_en, id_ex_en, ex_mem_bubble, state} !== 5'b00110) begin errors++; $display("FAIL mdu_wait cycle %0d: got %b want 00110", i, {pc_en, id_ex_en, ex_mem_bubble, state}); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        checks++; if ({pc_en, id_ex_en, ex_mem_bubble, state} !== 5'b11010) begin errors++; $display("FAIL mdu_done: got %b want 11010", {pc_en, id_ex_en, ex_mem_bubble, state}); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if ({state, stall_cycles} !== {2'b00, TCW'(3)}) begin errors++; $display("FAIL mdu_after: got state %b stalls %0d want 00/3", state, stall_cycles); end
        tick();
        drive(0, 0, 0, 0, 1, 1);
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL mdu_zero_wait_pc_en: got %0b want 1", pc_en); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if ({state, stall_cycles} !== {2'b00, TCW'(3)}) begin errors++; $display("FAIL mdu_zero_wait_after: got state %b stalls %0d want 00/3", state, stall_cycles); end
        tick();
    endtask

    task automatic test_branch();
        rst_dut();
        drive(0, 0, 0, 1, 0, 0);
        checks++; if ({if_id_flush, pc_en} !== 2'b11) begin errors++; $display("FAIL br_flush: got %b want 11", {if_id_flush, pc_en}); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if ({if_id_flush, flush_count} !== {1'b0, TCW'(1)}) begin errors++; $display("FAIL br_one_cycle: got flush %0b count %0d want 0/1", if_id_flush, flush_count); end
        tick();
        drive(0, 1, 0, 1, 0, 0);
        checks++; if (if_id_flush !== 1'b0) begin errors++; $display("FAIL br_hazard_suppress: got %0b want 0", if_id_flush); end
        tick();
        drive(0, 0, 1, 0, 0, 0);
        checks++; if ({id_ex_bubble, pc_en, id_ex_en} !== 3'b111) begin errors++; $display("FAIL noop_alone: got %b want 111", {id_ex_bubble, pc_en, id_ex_en}); end
        checks++; if ({flush_count, stall_cycles} !== {TCW'(1), TCW'(1)}) begin errors++; $display("FAIL br_counts: got %0d/%0d want 1/1", flush_count, stall_cycles); end
        tick();
    endtask

    task automatic test_mdu_ignore();
        rst_dut();
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 1, 0);
        checks++; if ({pc_en, id_ex_bubble, state} !== 4'b1001) begin errors++; $display("FAIL mdu_from_haz: got %b want 1001", {pc_en, id_ex_bubble, state}); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, 0, 0);
            checks++; if ({state, pc_en, if_id_flush, stall_timeout} !== 5'b10000) begin errors++; $display("FAIL mdu_ignore cycle %0d: got %b want 10000", i, {state, pc_en, if_id_flush, stall_timeout}); end
            tick();
        end
        drive(0, 1, 1, 1, 0, 1);
        checks++; if ({state, pc_en, if_id_flush, stall_timeout} !== 5'b10100) begin errors++; $display("FAIL mdu_ignore_done: got %b want 10100", {state, pc_en, if_id_flush, stall_timeout}); end
        tick();
        drive(0, 1, 0, 0, 0, 0);
        checks++; if ({state, flush_count, stall_timeout} !== {2'b00, TCW'(0), 1'b0}) begin errors++; $display("FAIL mdu_ignore_after: got state %b flushes %0d timeout %0b want 00/0/0", state, flush_count, stall_timeout); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL wd_held_in_mdu: got %0b want 1", stall_timeout); end
        tick();
    endtask

    task automatic test_reset_mdu();
        rst_dut();
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0);
        checks++; if ({pc_en, if_id_flush, ex_mem_bubble} !== 3'b011) begin errors++; $display("FAIL reset_in_mdu_forced: got %b want 011", {pc_en, if_id_flush, ex_mem_bubble}); end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        checks++; if ({state, pc_en, stall_cycles} !== {2'b00, 1'b1, TCW'(0)}) begin errors++; $display("FAIL reset_in_mdu_after: got state %b pc_en %0b stalls %0d want 00/1/0", state, pc_en, stall_cycles); end
        tick();
    endtask

    task automatic test_saturation();
        rst_dut();
        for (int i = 0; i < int'(MAXC) + 6; i++) begin
            drive(0, 1, 0, 0, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (stall_cycles !== MAXC) begin errors++; $display("FAIL stall_saturate: got %0d want %0d", stall_cycles, MAXC); end
        tick();
        drive(0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1);
        checks++; if (stall_cycles !== MAXC) begin errors++; $display("FAIL stall_saturate_hold: got %0d want %0d", stall_cycles, MAXC); end
        tick();
    endtask

    task automatic test_random();
        logic [9:0] got, exp;
        rst_dut();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0);
            got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, state, stall_timeout, 1'b0};
            exp = {e_pc, e_ifid, e_fl, e_idex, e_bub, e_exb, 2'(m_mode), m_to, 1'b0};
            checks++; if (got !== exp) begin errors++; $display("FAIL rand_ctrl cycle %0d: got %b want %b", i, got, exp); end
            checks++; if (stall_cycles !== TCW'(m_stall)) begin errors++; $display("FAIL rand_stall_cycles cycle %0d: got %0d want %0d", i, stall_cycles, m_stall); end
            checks++; if (flush_count !== TCW'(m_flush)) begin errors++; $display("FAIL rand_flush_count cycle %0d: got %0d want %0d", i, flush_count, m_flush); end
            tick();
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_hazard();
        test_mdu();
        test_branch();
        test_mdu_ignore();
        test_reset_mdu();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
